chan_scan_mux: RTL and testbench

Parametrised, registered N-channel data selector with a valid/ready output stage and an automatic round-robin scan mode. Next generation of the sensor-path 5:1, 12-bit selector. It adds configurable width and channel count, per-channel valid inputs, back-pressure, and a timed scan across an enable mask. It sits between the per-sensor front ends and the shared processing/transmit path. Each output word is tagged with the channel it came from.

---
 rtl/chan_scan_mux.sv | 139 +++++++++++++
 tb/tb_chan_scan_mux.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_scan_mux.sv
`timescale 1ns/1ps
// chan_scan_mux
// Registered N-channel data selector with a one-entry valid/ready output
// register and a timed round-robin scan over an enable mask. Every output
// word is tagged with the channel it came from.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   data_in      CHANNELS*WIDTH packed channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid     per-channel data valid
//   mode         0 = manual select via set, 1 = auto scan over chan_en
//   set          manual channel select (out-of-range values select channel 0)
//   chan_en      scan enable mask (ignored in manual mode)
//   dwell        cycles spent on each scanned channel (0 behaves as 1)
//   out_ready    downstream accept
//   data_out     registered selected data
//   out_valid    data_out holds a word not yet accepted
//   out_chan     source channel of data_out
//   scan_wrap    one-cycle pulse after a scan advance to a lower-or-equal index
//
// Handshake: a word transfers on any rising edge where out_valid and
// out_ready are both high. A new word may load on that same edge, so
// back-to-back transfers run at one word per cycle. While out_valid is high
// and out_ready is low the output register is frozen; samples that arrive
// during the stall are dropped rather than queued.
module chan_scan_mux #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 5,
  parameter int SEL_W    = 3,
  parameter int DWELL_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          set,
  input  logic [CHANNELS-1:0]       chan_en,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          data_out,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      scan_wrap
);

  logic [SEL_W-1:0]   cur_chan_q, cur_chan_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic [SEL_W-1:0]   out_chan_q, out_chan_d;
  logic               out_valid_q, out_valid_d;
  logic               scan_wrap_q, scan_wrap_d;

  logic [SEL_W-1:0]   next_en;
  logic [DWELL_W-1:0] dwell_tgt;
  logic [WIDTH-1:0]   sel_data;
  logic               eligible;
  logic               load;

  // First enabled channel searching cyclically from cur_chan+1. The loop runs
  // from the farthest offset down to the nearest so the nearest hit wins;
  // offset CHANNELS lands back on cur_chan itself, which covers the case of a
  // single enabled channel.
  always_comb begin
    next_en = cur_chan_q;
    for (int i = CHANNELS; i >= 1; i--) begin
      int idx;
      idx = int'(cur_chan_q) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (chan_en[idx]) next_en = SEL_W'(idx);
    end
  end

  // dwell = 0 and dwell = 1 both compare against 0, i.e. advance every cycle.
  assign dwell_tgt = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  assign sel_data = data_in[int'(cur_chan_q)*WIDTH +: WIDTH];
  assign eligible = !mode || chan_en[cur_chan_q];
  assign load     = (!out_valid_q || out_ready) && in_valid[cur_chan_q] && eligible;

  // Channel selection and scan timing
  always_comb begin
    cur_chan_d  = cur_chan_q;
    dwell_cnt_d = dwell_cnt_q;
    scan_wrap_d = 1'b0;
    if (!mode) begin
      cur_chan_d  = (int'(set) >= CHANNELS) ? '0 : set;
      dwell_cnt_d = '0;
    end else if (chan_en != '0) begin
      // A dwell change below the running count is not caught early: the
      // counter runs on through overflow and matches on the way round.
      if (dwell_cnt_q == dwell_tgt) begin
        dwell_cnt_d = '0;
        cur_chan_d  = next_en;
        scan_wrap_d = (next_en <= cur_chan_q);
      end else begin
        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
      end
    end
  end

  // One-entry output register
  always_comb begin
    data_out_d  = data_out_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    if (load) begin
      data_out_d  = sel_data;
      out_chan_d  = cur_chan_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_chan_q  <= '0;
      dwell_cnt_q <= '0;
      data_out_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      scan_wrap_q <= 1'b0;
    end else begin
      cur_chan_q  <= cur_chan_d;
      dwell_cnt_q <= dwell_cnt_d;
      data_out_q  <= data_out_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      scan_wrap_q <= scan_wrap_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_chan_scan_mux.sv
`timescale 1ns/1ps
// Directed bench for chan_scan_mux: a table of manual-select vectors plus
// hand-written sequences for back-pressure, masked scan, degenerate scan,
// invalid-input gating, asynchronous reset and a wider configuration.
module tb_chan_scan_mux;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 1: default parameters ----------------
  logic [59:0] data_in;
  logic [4:0]  in_valid;
  logic        mode;
  logic [2:0]  set;
  logic [4:0]  chan_en;
  logic [15:0] dwell;
  logic        out_ready;
  logic [11:0] data_out;
  logic        out_valid;
  logic [2:0]  out_chan;
  logic        scan_wrap;

  chan_scan_mux dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
    .mode(mode), .set(set), .chan_en(chan_en), .dwell(dwell),
    .out_ready(out_ready), .data_out(data_out), .out_valid(out_valid),
    .out_chan(out_chan), .scan_wrap(scan_wrap)
  );

  // ---------------- DUT 2: WIDTH=16, CHANNELS=8 ----------------
  logic [127:0] d2_data_in;
  logic [7:0]   d2_in_valid;
  logic         d2_mode;
  logic [2:0]   d2_set;
  logic [7:0]   d2_chan_en;
  logic [15:0]  d2_dwell;
  logic         d2_out_ready;
  logic [15:0]  d2_data_out;
  logic         d2_out_valid;
  logic [2:0]   d2_out_chan;
  logic         d2_scan_wrap;

  chan_scan_mux #(.WIDTH(16), .CHANNELS(8), .SEL_W(3), .DWELL_W(16)) dut2 (
    .clk(clk), .rst(rst), .data_in(d2_data_in), .in_valid(d2_in_valid),
    .mode(d2_mode), .set(d2_set), .chan_en(d2_chan_en), .dwell(d2_dwell),
    .out_ready(d2_out_ready), .data_out(d2_data_out), .out_valid(d2_out_valid),
    .out_chan(d2_out_chan), .scan_wrap(d2_scan_wrap)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [11:0] v);
    data_in[k*12 +: 12] = v;
  endtask

  task automatic set_default_data();
    for (int k = 0; k < 5; k++) set_data(k, 12'h100 + 12'(k));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"},  32'(data_out),  32'h0);
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_chan"},  32'(out_chan),  32'h0);
    chk({tag, "_wrap"},  32'(scan_wrap), 32'h0);
    chk({tag, "_d2data"},  32'(d2_data_out),  32'h0);
    chk({tag, "_d2valid"}, 32'(d2_out_valid), 32'h0);
    chk({tag, "_d2chan"},  32'(d2_out_chan),  32'h0);
    chk({tag, "_d2wrap"},  32'(d2_scan_wrap), 32'h0);
  endtask

  // ---------------- manual-select vector table ----------------
  typedef struct {
    logic [2:0]  set;
    logic        rdy;
    logic        exp_v;
    logic [2:0]  exp_chan;
    logic [11:0] exp_data;
  } man_vec_t;

  man_vec_t tbl[12];

  // Watchdog: the sequence is fixed-length, this only fires on a hang.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // set change lands in cur_chan on the first edge, capture on the second;
    // out-of-range set (6, 7) selects channel 0; ready=0 freezes the output.
    tbl[0]  = '{3'd3, 1'b1, 1'b1, 3'd0, 12'h100};
    tbl[1]  = '{3'd3, 1'b1, 1'b1, 3'd3, 12'h103};
    tbl[2]  = '{3'd6, 1'b1, 1'b1, 3'd3, 12'h103};
    tbl[3]  = '{3'd6, 1'b1, 1'b1, 3'd0, 12'h100};
    tbl[4]  = '{3'd1, 1'b1, 1'b1, 3'd0, 12'h100};
    tbl[5]  = '{3'd1, 1'b1, 1'b1, 3'd1, 12'h101};
    tbl[6]  = '{3'd7, 1'b1, 1'b1, 3'd1, 12'h101};
    tbl[7]  = '{3'd7, 1'b1, 1'b1, 3'd0, 12'h100};
    tbl[8]  = '{3'd4, 1'b0, 1'b1, 3'd0, 12'h100};
    tbl[9]  = '{3'd4, 1'b0, 1'b1, 3'd0, 12'h100};
    tbl[10] = '{3'd4, 1'b1, 1'b1, 3'd4, 12'h104};
    tbl[11] = '{3'd4, 1'b1, 1'b1, 3'd4, 12'h104};

    data_in   = '0;
    in_valid  = '0;
    mode      = 1'b0;
    set       = '0;
    chan_en   = '0;
    dwell     = '0;
    out_ready = 1'b0;
    d2_data_in   = '0;
    d2_in_valid  = '0;
    d2_mode      = 1'b0;
    d2_set       = '0;
    d2_chan_en   = '0;
    d2_dwell     = '0;
    d2_out_ready = 1'b1;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");

    // ---- manual select table ----
    set_default_data();
    in_valid = 5'b11111;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      set       = tbl[i].set;
      out_ready = tbl[i].rdy;
      step();
      chk($sformatf("man%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_v));
      chk($sformatf("man%0d_chan", i),  32'(out_chan),  32'(tbl[i].exp_chan));
      chk($sformatf("man%0d_data", i),  32'(data_out),  32'(tbl[i].exp_data));
      chk($sformatf("man%0d_wrap", i),  32'(scan_wrap), 32'h0);
    end

    // ---- back-pressure on channel 2 ----
    in_valid  = 5'b00100;
    set       = 3'd2;
    out_ready = 1'b1;
    set_data(2, 12'h200);
    step();                             // cur_chan -> 2, channel 4 invalid: drain
    chk("bp_drain_valid", 32'(out_valid), 32'h0);
    step();
    chk("bp_first_valid", 32'(out_valid), 32'h1);
    chk("bp_first_data",  32'(data_out),  32'h200);
    chk("bp_first_chan",  32'(out_chan),  32'h2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_data(2, 12'h201 + 12'(i));
      step();
      chk($sformatf("bp_stall%0d_data", i),  32'(data_out),  32'h200);
      chk($sformatf("bp_stall%0d_valid", i), 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    set_data(2, 12'h2aa);
    step();
    chk("bp_resume_data",  32'(data_out),  32'h2aa);
    chk("bp_resume_valid", 32'(out_valid), 32'h1);
    in_valid = 5'b00000;
    step();
    chk("bp_empty_valid", 32'(out_valid), 32'h0);
    chk("bp_empty_hold",  32'(data_out),  32'h2aa);

    // ---- scan with mask 10101, dwell 3 ----
    set_default_data();
    in_valid = 5'b11111;
    set      = 3'd0;
    step();                             // park cur_chan at 0
    mode    = 1'b1;
    dwell   = 16'd3;
    chan_en = 5'b10101;
    // cur_chan runs 0,0,0,2,2,2,4,4,4 and repeats; out_chan trails by one edge.
    for (int e = 1; e <= 18; e++) begin
      logic [2:0] ec;
      ec = 3'(2 * (((e - 1) / 3) % 3));
      step();
      chk($sformatf("scan%0d_valid", e), 32'(out_valid), 32'h1);
      chk($sformatf("scan%0d_chan", e),  32'(out_chan),  32'(ec));
      chk($sformatf("scan%0d_data", e),  32'(data_out),  32'h100 + 32'(ec));
      chk($sformatf("scan%0d_wrap", e),  32'(scan_wrap), (e % 9 == 0) ? 32'h1 : 32'h0);
    end

    // ---- degenerate scan: dwell 0, single enabled channel ----
    dwell   = 16'd0;
    chan_en = 5'b00100;
    step();                             // 0 -> 2, channel 0 now ineligible: drain
    chk("deg_first_valid", 32'(out_valid), 32'h0);
    chk("deg_first_wrap",  32'(scan_wrap), 32'h0);
    for (int e = 2; e <= 6; e++) begin
      step();
      chk($sformatf("deg%0d_valid", e), 32'(out_valid), 32'h1);
      chk($sformatf("deg%0d_chan", e),  32'(out_chan),  32'h2);
      chk($sformatf("deg%0d_data", e),  32'(data_out),  32'h102);
      chk($sformatf("deg%0d_wrap", e),  32'(scan_wrap), 32'h1);
    end
    chan_en = 5'b00000;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk($sformatf("noen%0d_valid", e), 32'(out_valid), 32'h0);
      chk($sformatf("noen%0d_wrap", e),  32'(scan_wrap), 32'h0);
    end

    // ---- invalid input gating: channel 1 never valid ----
    mode = 1'b0;
    set  = 3'd0;
    step();
    mode     = 1'b1;
    dwell    = 16'd2;
    chan_en  = 5'b11111;
    in_valid = 5'b11101;
    for (int e = 1; e <= 20; e++) begin
      int ec;
      ec = ((e - 1) / 2) % 5;
      step();
      chk($sformatf("gate%0d_valid", e), 32'(out_valid), (ec == 1) ? 32'h0 : 32'h1);
      if (ec != 1) begin
        chk($sformatf("gate%0d_chan", e), 32'(out_chan), 32'(ec));
        chk($sformatf("gate%0d_data", e), 32'(data_out), 32'h100 + 32'(ec));
      end
      chk($sformatf("gate%0d_wrap", e), 32'(scan_wrap), (e % 10 == 0) ? 32'h1 : 32'h0);
    end

    // ---- asynchronous reset mid-operation ----
    in_valid = 5'b11111;
    mode     = 1'b0;
    set      = 3'd0;
    step();
    mode  = 1'b1;
    dwell = 16'd3;
    repeat (5) step();                  // cur_chan = 1, dwell_cnt = 2, word pending
    chk("prerst_valid", 32'(out_valid), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    step();
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk($sformatf("post_rst%0d_valid", e), 32'(out_valid), 32'h1);
      chk($sformatf("post_rst%0d_chan", e),  32'(out_chan),  (e == 4) ? 32'h1 : 32'h0);
    end

    // ---- wide configuration: WIDTH=16, CHANNELS=8 ----
    for (int k = 0; k < 8; k++) d2_data_in[k*16 +: 16] = 16'h1000 + 16'(k) * 16'h111;
    d2_in_valid = 8'hff;
    d2_set      = 3'd7;
    step();
    chk("w_first_chan", 32'(d2_out_chan), 32'h0);
    chk("w_first_data", 32'(d2_data_out), 32'h1000);
    step();
    chk("w_sel_chan",  32'(d2_out_chan),  32'h7);
    chk("w_sel_data",  32'(d2_data_out),  32'h1777);
    chk("w_sel_valid", 32'(d2_out_valid), 32'h1);
    d2_mode    = 1'b1;
    d2_dwell   = 16'd1;
    d2_chan_en = 8'h81;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk($sformatf("w_scan%0d_chan", e), 32'(d2_out_chan),  (e == 2) ? 32'h0 : 32'h7);
      chk($sformatf("w_scan%0d_data", e), 32'(d2_data_out),  (e == 2) ? 32'h1000 : 32'h1777);
      chk($sformatf("w_scan%0d_wrap", e), 32'(d2_scan_wrap), (e == 2) ? 32'h0 : 32'h1);
    end

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
